stack_unit: RTL and testbench

LIFO operand stack for the stack-architecture multicycle datapath. Sits directly downstream of the datapath enable registers: the controller's registered push/pop strobes and the registered write-data value drive it. It presents top-of-stack (TOS) and next-on-stack (NOS) to the ALU operand registers in the following cycle. Holds up to DEPTH words, tracks occupancy, and flags overflow/underflow without corrupting contents.

---
 rtl/stack_unit_pkg.sv | 14 +
 rtl/stack_mem.sv | 27 ++
 rtl/stack_unit.sv | 99 +++++++++
 tb/tb_stack_unit.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/stack_unit_pkg.sv
// Shared constants for the operand stack: pointer width and the {push,pop} opcode
// encoding that the controller also drives.
package stack_unit_pkg;

  localparam int STACK_WIDTH = 32;
  localparam int STACK_DEPTH = 16;
  localparam int SP_W        = $clog2(STACK_DEPTH) + 1;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_REPL = 2'b11;

endpackage

// File: rtl/stack_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, two asynchronous
// read ports, no reset.
module stack_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/stack_unit.sv
// LIFO operand stack: occupancy count, sticky overflow/underflow flags, command
// decode and TOS/NOS masking around a stack_mem array.
module stack_unit
  import stack_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clr_flags,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         tos,
  output logic [WIDTH-1:0]         nos,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             mem_we;
  logic [CW-1:0]    wr_idx, tos_idx, nos_idx;
  logic [WIDTH-1:0] rd_tos, rd_nos;

  always_comb begin
    count_d     = count_q;
    overflow_d  = clr_flags ? 1'b0 : overflow_q;
    underflow_d = clr_flags ? 1'b0 : underflow_q;
    mem_we      = 1'b0;
    wr_idx      = count_q;
    tos_idx     = count_q - CW'(1);
    nos_idx     = count_q - CW'(2);
    case ({push, pop})
      OP_PUSH: begin
        if (full) begin
          overflow_d = 1'b1;
        end else begin
          mem_we  = 1'b1;
          count_d = count_q + CW'(1);
        end
      end
      OP_POP: begin
        if (empty) underflow_d = 1'b1;
        else       count_d     = count_q - CW'(1);
      end
      OP_REPL: begin
        if (empty) begin
          underflow_d = 1'b1;
        end else begin
          mem_we = 1'b1;
          wr_idx = tos_idx;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage has no reset, so gate the write to drop a command coinciding with reset.
  stack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we      (mem_we & ~reset),
    .waddr   (wr_idx[AW-1:0]),
    .wdata   (din),
    .raddr_a (tos_idx[AW-1:0]),
    .rdata_a (rd_tos),
    .raddr_b (nos_idx[AW-1:0]),
    .rdata_b (rd_nos)
  );

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign tos       = empty ? '0 : rd_tos;
  assign nos       = (count_q < CW'(2)) ? '0 : rd_nos;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_stack_unit.sv
// Directed self-checking bench for stack_unit using immediate assertions with
// hand-computed expected values.
module tb_stack_unit;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             push, pop, clr_flags;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] tos, nos;
  logic [4:0]       count;
  logic             empty, full, overflow, underflow;

  int errors = 0;
  int checks = 0;

  stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .clr_flags (clr_flags),
    .din       (din),
    .tos       (tos),
    .nos       (nos),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One command applied across one rising edge; outputs settle #1 after it.
  task automatic applyStimulus(input logic p, input logic q, input logic [WIDTH-1:0] d,
                               input logic c);
    @(negedge clk);
    push = p; pop = q; din = d; clr_flags = c;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; clr_flags = 1'b0; din = '0;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; clr_flags = 1'b0; din = '0;
    #12;
    checkOutput("rst_count", 64'(count), 64'd0);
    checkOutput("rst_empty", 64'(empty), 64'd1);
    checkOutput("rst_tos", 64'(tos), 64'd0);
    checkOutput("rst_nos", 64'(nos), 64'd0);
    checkOutput("rst_flags", 64'({overflow, underflow}), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(1, 0, 32'hA, 0);
    applyStimulus(1, 0, 32'hB, 0);
    applyStimulus(1, 0, 32'hC, 0);
    checkOutput("abc_count", 64'(count), 64'd3);
    checkOutput("abc_tos", 64'(tos), 64'hC);
    checkOutput("abc_nos", 64'(nos), 64'hB);
    applyStimulus(0, 1, 32'h0, 0);
    checkOutput("pop_count", 64'(count), 64'd2);
    checkOutput("pop_tos", 64'(tos), 64'hB);
    checkOutput("pop_nos", 64'(nos), 64'hA);

    doReset();
    for (int i = 1; i <= DEPTH; i++) applyStimulus(1, 0, 32'(i), 0);
    checkOutput("fill_full", 64'(full), 64'd1);
    checkOutput("fill_count", 64'(count), 64'd16);
    checkOutput("fill_tos", 64'(tos), 64'd16);
    checkOutput("fill_nos", 64'(nos), 64'd15);
    checkOutput("fill_ovf", 64'(overflow), 64'd0);
    applyStimulus(1, 0, 32'h99, 0);
    checkOutput("ovf_flag", 64'(overflow), 64'd1);
    checkOutput("ovf_count", 64'(count), 64'd16);
    checkOutput("ovf_tos", 64'(tos), 64'd16);
    applyStimulus(0, 0, 32'h0, 1);
    checkOutput("ovf_clr", 64'(overflow), 64'd0);
    applyStimulus(1, 1, 32'h77, 0);
    checkOutput("repl_full_count", 64'(count), 64'd16);
    checkOutput("repl_full_tos", 64'(tos), 64'h77);
    checkOutput("repl_full_nos", 64'(nos), 64'd15);
    checkOutput("repl_full_ovf", 64'(overflow), 64'd0);
    applyStimulus(1, 0, 32'h55, 1);
    checkOutput("clr_vs_set_ovf", 64'(overflow), 64'd1);
    checkOutput("clr_vs_set_tos", 64'(tos), 64'h77);

    doReset();
    checkOutput("rst2_ovf", 64'(overflow), 64'd0);
    applyStimulus(0, 1, 32'h0, 0);
    checkOutput("udf_flag", 64'(underflow), 64'd1);
    checkOutput("udf_count", 64'(count), 64'd0);
    checkOutput("udf_tos", 64'(tos), 64'd0);
    applyStimulus(1, 1, 32'h3, 0);
    checkOutput("udf_repl_flag", 64'(underflow), 64'd1);
    checkOutput("udf_repl_count", 64'(count), 64'd0);
    applyStimulus(0, 0, 32'h0, 1);
    checkOutput("udf_clr", 64'(underflow), 64'd0);
    applyStimulus(1, 1, 32'h3, 0);
    checkOutput("udf_repl_set", 64'(underflow), 64'd1);
    applyStimulus(0, 0, 32'h0, 1);

    applyStimulus(1, 0, 32'h5, 0);
    applyStimulus(1, 0, 32'h6, 0);
    applyStimulus(1, 1, 32'h7, 0);
    checkOutput("repl_count", 64'(count), 64'd2);
    checkOutput("repl_tos", 64'(tos), 64'h7);
    checkOutput("repl_nos", 64'(nos), 64'h5);
    checkOutput("repl_udf", 64'(underflow), 64'd0);

    applyStimulus(1, 0, 32'h21, 0);
    applyStimulus(1, 0, 32'h22, 0);
    applyStimulus(1, 0, 32'h23, 0);
    checkOutput("pre_rst_count", 64'(count), 64'd5);
    @(negedge clk);
    push = 1'b1; din = 32'hEE;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_count", 64'(count), 64'd0);
    checkOutput("mid_rst_tos", 64'(tos), 64'd0);
    checkOutput("mid_rst_nos", 64'(nos), 64'd0);
    @(posedge clk);
    #1;
    push = 1'b0; din = '0;
    checkOutput("mid_rst_hold", 64'(count), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1, 0, 32'h1, 0);
    checkOutput("post_rst_count", 64'(count), 64'd1);
    checkOutput("post_rst_tos", 64'(tos), 64'h1);
    checkOutput("post_rst_nos", 64'(nos), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
